// File: rtl/somador_ponto_flt.sv
`default_nettype none
// ============================================================================
// Module   : somador_ponto_flt
// Purpose  : Multi-cycle IEEE-754-style FP adder/subtractor, fixed 5-cycle latency.
// Options  : FPU_RNE_EN -> round to nearest even; undefined -> truncate.
// Revision : 1.0
// ============================================================================
module somador_ponto_flt #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     a,
    input  logic [EXP_W+FRAC_W:0]     b,
    input  logic                      sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     s,
    output logic [2:0]                flags
);

    localparam int W    = 1 + EXP_W + FRAC_W;
    localparam int SIGW = FRAC_W + 4;
    localparam int XW   = EXP_W + $clog2(FRAC_W + 5) + 2;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [XW-1:0] EMAX = $signed({{(XW-EXP_W){1'b0}}, {EXP_W{1'b1}}});

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        SOMA  = 3'd2,
        NORM  = 3'd3,
        ARRED = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                 state_q;
    logic [W-1:0]           a_q, b_q;
    logic                   spec_q;
    logic [W-1:0]           spec_res_q;
    logic [2:0]             spec_flg_q;
    logic                   sign_q, effsub_q;
    logic signed [XW-1:0]   exp_q;
    logic [SIGW-1:0]        sig_big_q, sig_sml_q, sig_n_q;
    logic [SIGW:0]          sum_q;
    logic                   out_valid_q;
    logic [W-1:0]           s_q;
    logic [2:0]             flags_q;

    // ---------------- capture-time classification ----------------
    logic                   sa_d, sb_d;
    logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                   spec_d;
    logic [W-1:0]           spec_res_d;
    logic [2:0]             spec_flg_d;

    assign sa_d   = a[W-1];
    assign sb_d   = b[W-1] ^ sub;
    assign a_zero = (a[W-2:FRAC_W] == '0);
    assign b_zero = (b[W-2:FRAC_W] == '0);
    assign a_inf  = (&a[W-2:FRAC_W]) && (a[FRAC_W-1:0] == '0);
    assign b_inf  = (&b[W-2:FRAC_W]) && (b[FRAC_W-1:0] == '0);
    assign a_nan  = (&a[W-2:FRAC_W]) && (a[FRAC_W-1:0] != '0);
    assign b_nan  = (&b[W-2:FRAC_W]) && (b[FRAC_W-1:0] != '0);

    always_comb begin
        spec_d     = 1'b1;
        spec_res_d = '0;
        spec_flg_d = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa_d != sb_d))) begin
            spec_res_d = QNAN;
            spec_flg_d = 3'b100;
        end else if (a_inf) begin
            spec_res_d = a;
        end else if (b_inf) begin
            spec_res_d = {sb_d, b[W-2:0]};
        end else if (a_zero && b_zero) begin
            spec_res_d = {sa_d & sb_d, {(W-1){1'b0}}};
        end else if (a_zero) begin
            spec_res_d = {sb_d, b[W-2:0]};
        end else if (b_zero) begin
            spec_res_d = a;
        end else begin
            spec_d = 1'b0;
        end
    end

    // ---------------- alignment ----------------
    logic                   swap_d;
    logic [W-1:0]           big_d, sml_d;
    logic [XW-1:0]          diff_d;
    logic signed [XW-1:0]   exp_big_d;
    logic [SIGW-1:0]        sig_big_d, sig_sml_d;
    logic [2*SIGW-1:0]      wide_d;

    always_comb begin
        swap_d    = (b_q[W-2:0] > a_q[W-2:0]);
        big_d     = swap_d ? b_q : a_q;
        sml_d     = swap_d ? a_q : b_q;
        exp_big_d = $signed(XW'(big_d[W-2:FRAC_W]));
        diff_d    = XW'(big_d[W-2:FRAC_W]) - XW'(sml_d[W-2:FRAC_W]);
        sig_big_d = {1'b1, big_d[FRAC_W-1:0], 3'b000};
        wide_d    = {1'b1, sml_d[FRAC_W-1:0], 3'b000, {SIGW{1'b0}}} >> diff_d;
        // Far-apart operands: only the sticky bit survives the shift.
        if (diff_d >= XW'(SIGW))
            sig_sml_d = {{(SIGW-1){1'b0}}, 1'b1};
        else
            sig_sml_d = {wide_d[2*SIGW-1:SIGW+1], wide_d[SIGW] | (|wide_d[SIGW-1:0])};
    end

    // ---------------- add / normalise ----------------
    logic [SIGW:0]          sum_d;
    logic [XW-1:0]          lz_d;
    logic                   found_d;
    logic [SIGW-1:0]        sig_n_d;
    logic signed [XW-1:0]   exp_n_d;

    assign sum_d = effsub_q ? ({1'b0, sig_big_q} - {1'b0, sig_sml_q})
                            : ({1'b0, sig_big_q} + {1'b0, sig_sml_q});

    always_comb begin
        lz_d    = '0;
        found_d = 1'b0;
        for (int i = SIGW - 1; i >= 0; i--) begin
            if (!found_d) begin
                if (sum_q[i]) found_d = 1'b1;
                else          lz_d    = lz_d + XW'(1);
            end
        end
        if (sum_q[SIGW]) begin
            sig_n_d = {sum_q[SIGW:2], sum_q[1] | sum_q[0]};
            exp_n_d = exp_q + XW'(1);
        end else begin
            sig_n_d = sum_q[SIGW-1:0] << lz_d;
            exp_n_d = exp_q - lz_d;
        end
    end

    // ---------------- rounding and result packing ----------------
    logic [FRAC_W+1:0]      mant_d;
    logic signed [XW-1:0]   exp_r_d;
    logic                   inexact_d;
    logic [W-1:0]           s_d;
    logic [2:0]             flags_d;

    always_comb begin
        inexact_d = |sig_n_q[2:0];
        mant_d    = {1'b0, sig_n_q[SIGW-1:3]};
        exp_r_d   = exp_q;
`ifdef FPU_RNE_EN
        if (sig_n_q[2] && (sig_n_q[1] || sig_n_q[0] || sig_n_q[3]))
            mant_d = mant_d + (FRAC_W+2)'(1);
`endif
        if (mant_d[FRAC_W+1]) begin
            mant_d  = mant_d >> 1;
            exp_r_d = exp_q + XW'(1);
        end

        // A normalised significand always has its hidden bit set, so a clear one means zero.
        if (spec_q) begin
            s_d     = spec_res_q;
            flags_d = spec_flg_q;
        end else if (!mant_d[FRAC_W]) begin
            s_d     = '0;
            flags_d = 3'b000;
        end else if (exp_r_d >= EMAX) begin
            s_d     = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags_d = 3'b011;
        end else if (exp_r_d[XW-1] || (exp_r_d == '0)) begin
            s_d     = {sign_q, {(W-1){1'b0}}};
            flags_d = 3'b001;
        end else begin
            s_d     = {sign_q, exp_r_d[EXP_W-1:0], mant_d[FRAC_W-1:0]};
            flags_d = {2'b00, inexact_d};
        end
    end

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= {sb_d, b[W-2:0]};
                        spec_q     <= spec_d;
                        spec_res_q <= spec_res_d;
                        spec_flg_q <= spec_flg_d;
                        state_q    <= ALIGN;
                    end
                end
                ALIGN: begin
                    sign_q    <= big_d[W-1];
                    effsub_q  <= a_q[W-1] ^ b_q[W-1];
                    exp_q     <= exp_big_d;
                    sig_big_q <= sig_big_d;
                    sig_sml_q <= sig_sml_d;
                    state_q   <= SOMA;
                end
                SOMA: begin
                    sum_q   <= sum_d;
                    state_q <= NORM;
                end
                NORM: begin
                    sig_n_q <= sig_n_d;
                    exp_q   <= exp_n_d;
                    state_q <= ARRED;
                end
                ARRED: begin
                    s_q     <= s_d;
                    flags_q <= flags_d;
                    state_q <= DONE;
                end
                DONE: begin
                    // Result is presented one cycle after entering DONE, giving a 5-cycle latency.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign flags     = flags_q;

endmodule
`default_nettype wire
